// File: rtl/quad_encoder_gen_pkg.sv
// Shared types and constants for the quadrature encoder emulator.
// Phase index 0..3 maps to Gray-coded (A,B) so adjacent phases differ in one bit.
package quad_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef logic [1:0] phase_t;

    localparam logic [1:0] AB_PH0 = 2'b00;
    localparam logic [1:0] AB_PH1 = 2'b10;
    localparam logic [1:0] AB_PH2 = 2'b11;
    localparam logic [1:0] AB_PH3 = 2'b01;

    // -1 on a 2-bit index is +3
    localparam phase_t STEP_CW  = 2'd1;
    localparam phase_t STEP_CCW = 2'd3;

    function automatic logic [1:0] phase_to_ab(input phase_t ph);
        case (ph)
            2'd0:    phase_to_ab = AB_PH0;
            2'd1:    phase_to_ab = AB_PH1;
            2'd2:    phase_to_ab = AB_PH2;
            default: phase_to_ab = AB_PH3;
        endcase
    endfunction

endpackage

// File: rtl/quad_encoder_gen_if.sv
// Move-command handshake between a command source and quad_encoder_gen.
interface quad_encoder_gen_if #(
    parameter int COUNT_WIDTH = 8,
    parameter int DIV_WIDTH   = 16
);
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [COUNT_WIDTH-1:0] cmd_steps;
    logic                   cmd_dir;
    logic [DIV_WIDTH-1:0]   cmd_period;

    modport master (output cmd_valid, cmd_steps, cmd_dir, cmd_period, input cmd_ready);
    modport slave  (input cmd_valid, cmd_steps, cmd_dir, cmd_period, output cmd_ready);
endinterface

// File: rtl/quad_encoder_gen_tick_timer.sv
// Loadable down-counter that pulses tick at zero and reloads the last loaded value.
module quad_tick_timer #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [DIV_WIDTH-1:0] value,
    input  logic                 en,
    output logic                 tick
);
    logic [DIV_WIDTH-1:0] count;
    logic [DIV_WIDTH-1:0] reload;

    assign tick = en && (count == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            reload <= '0;
        end else if (load) begin
            count  <= value;
            reload <= value;
        end else if (tick) begin
            count  <= reload;
        end else if (en) begin
            count  <= count - 1'b1;
        end
    end
endmodule

// File: rtl/quad_encoder_gen.sv
// Quadrature encoder emulator: emits a commanded number of Gray-code A/B steps
// at a fixed edge spacing, tracking a wrapping signed position.
module quad_encoder_gen
    import quad_gen_pkg::*;
#(
    parameter int COUNT_WIDTH = 8,
    parameter int DIV_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    quad_encoder_gen_if.slave      cmd,
    input  logic                   abort,
    output logic                   enc_a,
    output logic                   enc_b,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] position
);
    state_e                 state;
    phase_t                 phase;
    phase_t                 phase_nxt;
    logic                   dir;
    logic [COUNT_WIDTH-1:0] remaining;
    logic                   accept;
    logic                   tmr_en;
    logic                   tick;
    logic [DIV_WIDTH-1:0]   load_val;

    assign cmd.cmd_ready = (state == IDLE);
    assign busy          = (state != IDLE);
    assign accept        = (state == IDLE) && cmd.cmd_valid;
    // Period 0 behaves as 1, so the timer reload is max(period,1)-1.
    assign load_val      = (cmd.cmd_period == '0) ? '0 : cmd.cmd_period - 1'b1;
    // Abort gates the timer so a same-cycle expiry produces no transition.
    assign tmr_en        = (state == RUN) && !abort && (remaining != '0);
    assign phase_nxt     = phase + (dir ? STEP_CW : STEP_CCW);

    quad_tick_timer #(.DIV_WIDTH(DIV_WIDTH)) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .value (load_val),
        .en    (tmr_en),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            phase     <= '0;
            dir       <= 1'b0;
            remaining <= '0;
            enc_a     <= 1'b0;
            enc_b     <= 1'b0;
            position  <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd.cmd_valid) begin
                        remaining <= cmd.cmd_steps;
                        dir       <= cmd.cmd_dir;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (remaining == '0) begin
                        // zero-step move: one RUN cycle, then the DONE pulse
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (tick) begin
                        phase          <= phase_nxt;
                        {enc_a, enc_b} <= phase_to_ab(phase_nxt);
                        position       <= dir ? position + 1'b1 : position - 1'b1;
                        remaining      <= remaining - 1'b1;
                        if (remaining == COUNT_WIDTH'(1)) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
